// File: rtl/qed_pkg.sv
// Shared opcodes, FSM states and instruction classes for the SQED duplicate sequencer.
package qed_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {ST_ORIG, ST_DUP, ST_DONE} state_e;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_LOAD, CLS_STORE, CLS_RI, CLS_RR, CLS_CSR
  } instr_class_e;

  // CLS_NONE covers branches, JAL, LUI, AUIPC, FENCE and ECALL/EBREAK.
  function automatic instr_class_e classify(input logic [6:0] opcode, input logic [2:0] funct3);
    instr_class_e c;
    c = CLS_NONE;
    case (opcode)
      OPC_LOAD:                           c = CLS_LOAD;
      OPC_STORE:                          c = CLS_STORE;
      OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR: c = CLS_RI;
      OPC_OP, OPC_OP32:                   c = CLS_RR;
      OPC_SYSTEM:                         c = (funct3 != 3'b000) ? CLS_CSR : CLS_NONE;
      default:                            c = CLS_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/qed_dup_transform.sv
// Combinational EDDI-V rewrite: flags eligible instructions and builds the duplicate
// that targets the upper register half and the upper memory region.
module qed_dup_transform
  import qed_pkg::*;
#(
  parameter int REG_W         = 5,
  parameter int MEM_SPLIT_BIT = 7
) (
  input  logic [31:0] instr,
  output logic        eligible,
  output logic [31:0] dup_instr
);

  localparam logic [4:0]  REG_LOW = 5'((1 << (REG_W - 1)) - 1);
  localparam logic [4:0]  REG_TOP = 5'(1 << (REG_W - 1));
  localparam logic [11:0] IMM_LOW = 12'((1 << MEM_SPLIT_BIT) - 1);
  localparam logic [11:0] IMM_TOP = 12'(1 << MEM_SPLIT_BIT);

  instr_class_e cls;
  logic [4:0]   rd_dup, rs1_dup, rs2_dup;
  logic [11:0]  ld_imm, st_imm;

  // x0 stays x0 so that hard-wired zero reads are preserved in the duplicate.
  function automatic logic [4:0] remap(input logic [4:0] idx);
    return (idx == 5'd0) ? idx : ((idx & REG_LOW) | REG_TOP);
  endfunction

  function automatic logic [11:0] split_imm(input logic [11:0] imm);
    return (imm & IMM_LOW) | IMM_TOP;
  endfunction

  always_comb begin
    cls     = classify(instr[6:0], instr[14:12]);
    rd_dup  = remap(instr[11:7]);
    rs1_dup = remap(instr[19:15]);
    rs2_dup = remap(instr[24:20]);
    ld_imm  = split_imm(instr[31:20]);
    st_imm  = split_imm({instr[31:25], instr[11:7]});
    eligible  = (cls != CLS_NONE);
    dup_instr = instr;
    case (cls)
      CLS_LOAD:  dup_instr = {ld_imm, 5'd0, instr[14:12], rd_dup, instr[6:0]};
      CLS_STORE: dup_instr = {st_imm[11:5], rs2_dup, 5'd0, instr[14:12], st_imm[4:0], instr[6:0]};
      CLS_RI:    dup_instr = {instr[31:20], rs1_dup, instr[14:12], rd_dup, instr[6:0]};
      CLS_RR:    dup_instr = {instr[31:25], rs2_dup, rs1_dup, instr[14:12], rd_dup, instr[6:0]};
      CLS_CSR:   dup_instr = {instr[31:12], rd_dup, instr[6:0]};
      default:   dup_instr = instr;
    endcase
  end

endmodule

// File: rtl/qed_dup_sequencer.sv
// Sequential EDDI-V issue stage: forwards originals while recording them, then replays
// the recorded instructions as duplicates and tracks the commit balance.
module qed_dup_sequencer
  import qed_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int REG_W         = 5,
  parameter int MEM_SPLIT_BIT = 7,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [31:0]      ifu_instruction,
  input  logic             ifu_valid,
  output logic             ifu_ready,
  input  logic             exec_dup,
  input  logic             core_stall,
  output logic [31:0]      qed_instruction,
  output logic             qed_valid,
  output logic             qed_is_dup,
  output logic             qed_ready,
  output logic [CNT_W-1:0] orig_count,
  output logic [CNT_W-1:0] dup_count,
  output logic             fifo_full
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e      state_reg;
  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic        qed_cnt_reg;
  logic        ld, xfer, push, pop, pop_last, accept, fifo_empty;
  logic        in_eligible, head_eligible;
  logic [31:0] head_instr, head_dup;
  logic [31:0] push_dup_unused;

  qed_dup_transform #(.REG_W(REG_W), .MEM_SPLIT_BIT(MEM_SPLIT_BIT)) u_push_xform (
    .instr     (ifu_instruction),
    .eligible  (in_eligible),
    .dup_instr (push_dup_unused)
  );

  qed_dup_transform #(.REG_W(REG_W), .MEM_SPLIT_BIT(MEM_SPLIT_BIT)) u_pop_xform (
    .instr     (head_instr),
    .eligible  (head_eligible),
    .dup_instr (head_dup)
  );

  assign ld          = !qed_valid || !core_stall;
  assign accept      = qed_valid && !core_stall;
  assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign rd_ptr_next = rd_ptr_reg + 1'b1;
  assign head_instr  = mem[rd_ptr_reg[AW-1:0]];

  always_comb begin
    ifu_ready = 1'b0;
    if (!rst) begin
      if (!ena)
        ifu_ready = ld;
      else if (state_reg == ST_ORIG)
        ifu_ready = ld && !fifo_full && !exec_dup;
    end
  end

  assign xfer     = ifu_valid && ifu_ready;
  assign push     = ena && (state_reg == ST_ORIG) && xfer && in_eligible;
  assign pop      = ena && (state_reg == ST_DUP) && ld;
  assign pop_last = pop && (rd_ptr_next == wr_ptr_reg);

  assign qed_ready = (orig_count == dup_count) && (orig_count != '0) && fifo_empty && !qed_valid;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg[AW-1:0]] <= ifu_instruction;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_ORIG;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      qed_instruction <= '0;
      qed_valid       <= 1'b0;
      qed_is_dup      <= 1'b0;
      qed_cnt_reg     <= 1'b0;
      orig_count      <= '0;
      dup_count       <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_next;

      // qed_cnt_reg tags the entry in the output register as one that participates in the balance.
      if (accept && qed_cnt_reg && ena) begin
        if (qed_is_dup) begin
          if (dup_count != CNT_MAX) dup_count <= dup_count + 1'b1;
        end else if (orig_count != CNT_MAX) begin
          orig_count <= orig_count + 1'b1;
        end
      end

      if (!ena) begin
        if (xfer) begin
          qed_instruction <= ifu_instruction;
          qed_valid       <= 1'b1;
          qed_is_dup      <= 1'b0;
          qed_cnt_reg     <= 1'b0;
        end else if (ld) begin
          qed_valid <= 1'b0;
        end
      end else begin
        case (state_reg)
          ST_ORIG: begin
            if (xfer) begin
              qed_instruction <= ifu_instruction;
              qed_valid       <= 1'b1;
              qed_is_dup      <= 1'b0;
              qed_cnt_reg     <= in_eligible;
            end else if (ld) begin
              qed_valid <= 1'b0;
            end
            if (exec_dup && !fifo_empty) state_reg <= ST_DUP;
          end
          ST_DUP: begin
            if (ld) begin
              qed_instruction <= head_dup;
              qed_valid       <= 1'b1;
              qed_is_dup      <= 1'b1;
              qed_cnt_reg     <= head_eligible;
              if (pop_last) state_reg <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (ld) qed_valid <= 1'b0;
            if (!exec_dup) state_reg <= ST_ORIG;
          end
          default: state_reg <= ST_ORIG;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Scoreboard bench for qed_dup_sequencer: stimulus queues hand-computed outputs,
// a monitor pops and compares each instruction the core accepts.
module tb_qed_dup_sequencer;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, ena, ifu_valid, ifu_ready, exec_dup, core_stall;
  logic [31:0]      ifu_instruction, qed_instruction;
  logic             qed_valid, qed_is_dup, qed_ready, fifo_full;
  logic [CNT_W-1:0] orig_count, dup_count;

  typedef struct packed {
    logic [31:0] instr;
    logic        is_dup;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [31:0] T3_ORIG [8] = '{
    32'h00000133, 32'h002081B3, 32'h02502223, 32'h34039373,
    32'hFFF4841B, 32'h000280E7, 32'h40C5853B, 32'h001A0A13};
  localparam logic [31:0] T3_DUP [8] = '{
    32'h00000933, 32'h012889B3, 32'h0B502223, 32'h34039B73,
    32'hFFFC8C1B, 32'h000A88E7, 32'h41CD8D3B, 32'h001A0A13};

  always #5 clk = ~clk;

  qed_dup_sequencer #(.DEPTH(8), .REG_W(5), .MEM_SPLIT_BIT(7), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .ena             (ena),
    .ifu_instruction (ifu_instruction),
    .ifu_valid       (ifu_valid),
    .ifu_ready       (ifu_ready),
    .exec_dup        (exec_dup),
    .core_stall      (core_stall),
    .qed_instruction (qed_instruction),
    .qed_valid       (qed_valid),
    .qed_is_dup      (qed_is_dup),
    .qed_ready       (qed_ready),
    .orig_count      (orig_count),
    .dup_count       (dup_count),
    .fifo_full       (fifo_full)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: every accepted output must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && qed_valid && !core_stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=0x%08h dup=%0b required=none",
                   qed_instruction, qed_is_dup);
        end else begin
          e = exp_q.pop_front();
          $display("accept instr=0x%08h dup=%0b orig=%0d dup_cnt=%0d",
                   qed_instruction, qed_is_dup, orig_count, dup_count);
          chk("out_instr", qed_instruction, e.instr);
          chk("out_is_dup", 32'(qed_is_dup), 32'(e.is_dup));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b1; ifu_valid = 1'b0; ifu_instruction = '0;
    exec_dup = 1'b0; core_stall = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] instr);
    bit got;
    got = 1'b0;
    ifu_instruction = instr;
    ifu_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ifu_ready) begin
        exp_q.push_back('{instr: instr, is_dup: 1'b0});
        got = 1'b1;
      end
      tick();
    end
    ifu_valid = 1'b0;
    chk("send_accepted", 32'(got), 32'd1);
  endtask

  task automatic push_dup(input logic [31:0] d);
    exp_q.push_back('{instr: d, is_dup: 1'b1});
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (!qed_valid) ok = 1'b1;
    end
    chk("drain_in_time", 32'(ok), 32'd1);
  endtask

  task automatic wait_ready(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (qed_ready) ok = 1'b1;
    end
    chk("qed_ready_in_time", 32'(ok), 32'd1);
  endtask

  task automatic wait_valid(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (qed_valid) ok = 1'b1;
    end
    chk("valid_in_time", 32'(ok), 32'd1);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; ifu_valid = 1'b0; ifu_instruction = '0;
    exec_dup = 1'b0; core_stall = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_qed_valid", 32'(qed_valid), 32'd0);
    chk("rst_qed_instr", qed_instruction, 32'd0);
    chk("rst_qed_is_dup", 32'(qed_is_dup), 32'd0);
    chk("rst_orig_count", 32'(orig_count), 32'd0);
    chk("rst_dup_count", 32'(dup_count), 32'd0);
    chk("rst_qed_ready", 32'(qed_ready), 32'd0);
    chk("rst_fifo_full", 32'(fifo_full), 32'd0);
    chk("rst_ifu_ready", 32'(ifu_ready), 32'd1);
    tick();

    // addi x1,x1,5 and its duplicate on x17
    send(32'h00508093);
    wait_drain();
    chk("t1_orig_count", 32'(orig_count), 32'd1);
    tick();
    exec_dup = 1'b1;
    push_dup(32'h00588893);
    wait_ready(10);
    chk("t1_dup_count", 32'(dup_count), 32'd1);
    chk("t1_qed_ready", 32'(qed_ready), 32'd1);
    tick();
    exec_dup = 1'b0;

    // Loads: rs1 forced to x0, immediate moved into the upper region
    do_reset();
    send(32'h01002183);
    send(32'h1F412203);
    wait_drain();
    chk("t2_orig_count", 32'(orig_count), 32'd2);
    tick();
    exec_dup = 1'b1;
    push_dup(32'h09002983);
    push_dup(32'h0F402A03);
    wait_ready(15);
    chk("t2_dup_count", 32'(dup_count), 32'd2);
    tick();
    exec_dup = 1'b0;

    // Fill all entries, then replay in order
    do_reset();
    for (int i = 0; i < 8; i++) send(T3_ORIG[i]);
    @(negedge clk);
    chk("t3_fifo_full", 32'(fifo_full), 32'd1);
    chk("t3_ifu_ready_blocked", 32'(ifu_ready), 32'd0);
    tick();
    exec_dup = 1'b1;
    for (int i = 0; i < 8; i++) push_dup(T3_DUP[i]);
    wait_ready(40);
    chk("t3_orig_count", 32'(orig_count), 32'd8);
    chk("t3_dup_count", 32'(dup_count), 32'd8);
    chk("t3_fifo_drained", 32'(fifo_full), 32'd0);
    tick();
    exec_dup = 1'b0;

    // Stall during replay: output held, one count per release
    do_reset();
    for (int i = 0; i < 3; i++) send(T3_ORIG[i]);
    wait_drain();
    tick();
    exec_dup = 1'b1;
    core_stall = 1'b1;
    for (int i = 0; i < 3; i++) push_dup(T3_DUP[i]);
    for (int k = 0; k < 3; k++) begin
      wait_valid(10);
      for (int s = 0; s < 3; s++) begin
        if (s != 0) @(negedge clk);
        chk("t4_stall_hold_instr", qed_instruction, T3_DUP[k]);
        chk("t4_stall_hold_count", 32'(dup_count), 32'(k));
      end
      tick();
      core_stall = 1'b0;
      tick();
      core_stall = 1'b1;
      @(negedge clk);
      chk("t4_release_count", 32'(dup_count), 32'(k + 1));
    end
    chk("t4_qed_ready", 32'(qed_ready), 32'd1);
    tick();
    exec_dup = 1'b0;
    core_stall = 1'b0;

    // Non-eligible classes issue but are not counted; exec_dup on empty stays in ORIG
    do_reset();
    send(32'h00208463);
    send(32'h123452B7);
    send(32'h00000073);
    wait_drain();
    chk("t5_noelig_count", 32'(orig_count), 32'd0);
    tick();
    exec_dup = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("t5_empty_no_output", 32'(qed_valid), 32'd0);
    chk("t5_empty_qed_ready", 32'(qed_ready), 32'd0);
    tick();
    exec_dup = 1'b0;
    @(negedge clk);
    chk("t5_still_orig", 32'(ifu_ready), 32'd1);
    tick();
    send(32'h00000133);
    wait_drain();
    chk("t5_add_counted", 32'(orig_count), 32'd1);
    tick();
    exec_dup = 1'b1;
    push_dup(32'h00000933);
    wait_ready(10);
    chk("t5_dup_count", 32'(dup_count), 32'd1);
    tick();
    exec_dup = 1'b0;

    // Reset in the middle of a replay with 3 entries left
    do_reset();
    for (int i = 0; i < 4; i++) send(T3_ORIG[i]);
    wait_drain();
    tick();
    exec_dup = 1'b1;
    core_stall = 1'b1;
    wait_valid(10);
    chk("t6_held_dup", qed_instruction, T3_DUP[0]);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_rst_valid", 32'(qed_valid), 32'd0);
    chk("t6_rst_instr", qed_instruction, 32'd0);
    chk("t6_rst_is_dup", 32'(qed_is_dup), 32'd0);
    chk("t6_rst_orig", 32'(orig_count), 32'd0);
    chk("t6_rst_dup", 32'(dup_count), 32'd0);
    chk("t6_rst_ready", 32'(qed_ready), 32'd0);
    chk("t6_rst_full", 32'(fifo_full), 32'd0);
    chk("t6_rst_ifu_ready", 32'(ifu_ready), 32'd0);
    tick();
    rst = 1'b0; exec_dup = 1'b0; core_stall = 1'b0;
    ifu_instruction = 32'h00508093;
    ifu_valid = 1'b1;
    exp_q.push_back('{instr: 32'h00508093, is_dup: 1'b0});
    @(negedge clk);
    chk("t6_accept_after_rst", 32'(ifu_ready), 32'd1);
    tick();
    ifu_valid = 1'b0;
    wait_drain();
    chk("t6_orig_count", 32'(orig_count), 32'd1);
    tick();
    exec_dup = 1'b1;
    push_dup(32'h00588893);
    wait_ready(10);
    chk("t6_dup_count", 32'(dup_count), 32'd1);
    tick();
    exec_dup = 1'b0;

    // Bypass: no recording, no counting, FSM held
    do_reset();
    ena = 1'b0;
    send(32'h01002183);
    wait_drain();
    chk("t7_bypass_orig", 32'(orig_count), 32'd0);
    tick();
    exec_dup = 1'b1;
    @(negedge clk);
    chk("t7_bypass_ready", 32'(ifu_ready), 32'd1);
    tick();
    tick();
    @(negedge clk);
    chk("t7_bypass_no_dup", 32'(qed_valid), 32'd0);
    tick();
    exec_dup = 1'b0;
    ena = 1'b1;
    tick();
    exec_dup = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("t7_nothing_recorded", 32'(qed_valid), 32'd0);
    chk("t7_qed_ready", 32'(qed_ready), 32'd0);
    chk("t7_dup_count", 32'(dup_count), 32'd0);
    tick();
    exec_dup = 1'b0;
    tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
